burst_ram_arbiter: RTL

BURST_RAM_ARBITER -- requirements
Module: burst_ram_arbiter

---
 rtl/burst_ram_pkg.sv | 17 +
 rtl/burst_ram_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/burst_ram_pkg.sv
// Shared types and defaults for the two-requester burst RAM arbiter.
package burst_ram_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WRITE_BEATS = 2'd1,
    READ_WAIT   = 2'd2,
    READ_BEATS  = 2'd3
  } state_t;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam int unsigned DEFAULT_BURST_BEATS            = 4;
  localparam int unsigned DEFAULT_COMMAND_DELAY_INTERVAL = 13;

endpackage

// File: rtl/burst_ram_arbiter.sv
// Round-robin arbiter sharing one burst RAM command port between two requesters,
// with a minimum spacing between commands and per-owner read-data steering.
module burst_ram_arbiter
  import burst_ram_pkg::*;
#(
  parameter int unsigned RAM_DEPTH_BITWIDTH     = 21,
  parameter int unsigned COMMAND_DELAY_INTERVAL = DEFAULT_COMMAND_DELAY_INTERVAL,
  parameter int unsigned BURST_BEATS            = DEFAULT_BURST_BEATS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          c0_cmd,
  input  logic                          c0_cmd_en,
  input  logic [RAM_DEPTH_BITWIDTH-1:0] c0_addr,
  input  logic [63:0]                   c0_wr_data,
  output logic                          c0_ack,
  output logic [63:0]                   c0_rd_data,
  output logic                          c0_rd_data_valid,
  input  logic                          c1_cmd,
  input  logic                          c1_cmd_en,
  input  logic [RAM_DEPTH_BITWIDTH-1:0] c1_addr,
  input  logic [63:0]                   c1_wr_data,
  output logic                          c1_ack,
  output logic [63:0]                   c1_rd_data,
  output logic                          c1_rd_data_valid,
  output logic                          br_cmd,
  output logic                          br_cmd_en,
  output logic [RAM_DEPTH_BITWIDTH-1:0] br_addr,
  output logic [63:0]                   br_wr_data,
  output logic [7:0]                    br_data_mask,
  input  logic [63:0]                   br_rd_data,
  input  logic                          br_rd_data_valid
);

  localparam int unsigned DLY_W  = (COMMAND_DELAY_INTERVAL < 1) ? 1 : $clog2(COMMAND_DELAY_INTERVAL + 1);
  localparam int unsigned BEAT_W = $clog2(BURST_BEATS + 1);

  state_t                        state, state_d;
  logic [DLY_W-1:0]              dly_cnt, dly_d;
  logic [BEAT_W-1:0]             beat_cnt, beat_d;
  logic                          owner, owner_d;
  logic                          last_grant, last_d;
  logic                          cmd_en_d, ack0_d, ack1_d, cmd_d;
  logic [RAM_DEPTH_BITWIDTH-1:0] addr_d;
  logic [63:0]                   wdata_d;

  logic                          grant, sel, sel_cmd, read_last;
  logic [RAM_DEPTH_BITWIDTH-1:0] sel_addr;
  logic [63:0]                   sel_wdata;

  // Ties go to whichever requester did not win last time.
  assign grant     = (state == IDLE) && (dly_cnt == '0) && (c0_cmd_en || c1_cmd_en);
  assign sel       = (c0_cmd_en && c1_cmd_en) ? ~last_grant : c1_cmd_en;
  assign sel_cmd   = sel ? c1_cmd : c0_cmd;
  assign sel_addr  = sel ? c1_addr : c0_addr;
  assign sel_wdata = sel ? c1_wr_data : c0_wr_data;
  assign read_last = br_rd_data_valid && ((beat_cnt + BEAT_W'(1)) == BEAT_W'(BURST_BEATS));

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dly_cnt    <= '0;
      beat_cnt   <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      br_cmd_en  <= 1'b0;
      br_cmd     <= 1'b0;
      br_addr    <= '0;
      br_wr_data <= '0;
      c0_ack     <= 1'b0;
      c1_ack     <= 1'b0;
    end else begin
      state      <= state_d;
      dly_cnt    <= dly_d;
      beat_cnt   <= beat_d;
      owner      <= owner_d;
      last_grant <= last_d;
      br_cmd_en  <= cmd_en_d;
      br_cmd     <= cmd_d;
      br_addr    <= addr_d;
      br_wr_data <= wdata_d;
      c0_ack     <= ack0_d;
      c1_ack     <= ack1_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (grant) begin
          if (sel_cmd == CMD_WRITE) state_d = (BURST_BEATS > 1) ? WRITE_BEATS : IDLE;
          else                      state_d = READ_WAIT;
        end
      end
      WRITE_BEATS: if (beat_cnt == BEAT_W'(BURST_BEATS - 1)) state_d = IDLE;
      READ_WAIT: begin
        if (read_last)             state_d = IDLE;
        else if (br_rd_data_valid) state_d = READ_BEATS;
      end
      READ_BEATS: if (read_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs and counters.
  always_comb begin
    cmd_en_d = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    cmd_d    = br_cmd;
    addr_d   = br_addr;
    wdata_d  = br_wr_data;
    owner_d  = owner;
    last_d   = last_grant;
    beat_d   = beat_cnt;
    dly_d    = (dly_cnt == '0) ? '0 : dly_cnt - DLY_W'(1);
    case (state)
      IDLE: begin
        if (grant) begin
          cmd_en_d = 1'b1;
          cmd_d    = sel_cmd;
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          ack0_d   = ~sel;
          ack1_d   = sel;
          owner_d  = sel;
          last_d   = sel;
          dly_d    = DLY_W'(COMMAND_DELAY_INTERVAL);
          beat_d   = (sel_cmd == CMD_WRITE) ? BEAT_W'(1) : '0;
        end
      end
      WRITE_BEATS: begin
        wdata_d = owner ? c1_wr_data : c0_wr_data;
        beat_d  = beat_cnt + BEAT_W'(1);
      end
      READ_WAIT, READ_BEATS: if (br_rd_data_valid) beat_d = beat_cnt + BEAT_W'(1);
      default: ;
    endcase
  end

  // Read data is broadcast; only the current read owner sees valid.
  logic reading;
  assign reading          = (state == READ_WAIT) || (state == READ_BEATS);
  assign c0_rd_data       = br_rd_data;
  assign c1_rd_data       = br_rd_data;
  assign c0_rd_data_valid = reading && !owner && br_rd_data_valid;
  assign c1_rd_data_valid = reading && owner && br_rd_data_valid;
  assign br_data_mask     = 8'h00;

endmodule
